// File: rtl/cnn_frame_sequencer_if.sv
// Pixel stream and CNN core control bundle; the sequencer drives it as master and the CNN core is the slave.
interface cnn_frame_sequencer_if #(
    parameter int PIXEL_W = 8
);
    logic               cnn_start;
    logic               cnn_reset;
    logic               cnn_busy;
    logic               cnn_result_valid;
    logic               pix_out_valid;
    logic               pix_out_ready;
    logic [PIXEL_W-1:0] pix_out_data;

    modport master (
        output cnn_start, cnn_reset, pix_out_valid, pix_out_data,
        input  cnn_busy, cnn_result_valid, pix_out_ready
    );
    modport slave (
        input  cnn_start, cnn_reset, pix_out_valid, pix_out_data,
        output cnn_busy, cnn_result_valid, pix_out_ready
    );
endinterface

// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer between the register file and the CNN core: control edges become registered one-cycle pulses;
// pixels leave a first-word-fallthrough FIFO on valid/ready, and a push into a full FIFO with no pop that cycle is dropped.
module cnn_frame_sequencer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full,
    output logic [AW:0]  level
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (level == '0);
    assign full     = (level == FULL_LVL);
    assign do_pop   = pop & ~empty & ~flush;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push & (~full | do_pop) & ~flush;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module cnn_frame_sequencer #(
    parameter int PIXEL_W        = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int FRAME_PIXELS   = 1024,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           control_reg,
    input  logic [31:0]           pixel_reg,
    output logic [31:0]           status_reg,
    output logic [CNT_W-1:0]      frame_count_reg,
    output logic [31:0]           error_code_reg,
    output logic                  frame_start,
    output logic                  frame_complete,
    output logic                  irq,
    cnn_frame_sequencer_if.master cnn
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] FRAME_LEN = 32'(FRAME_PIXELS);
    localparam logic [31:0] WD_LAST   = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READY = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t             state;
    logic [5:0]         ctrl_d1;
    logic               res_d1;
    logic [31:0]        pixel_count;
    logic [31:0]        watchdog;
    logic               done;
    logic               cnn_start_q;
    logic               cnn_reset_q;
    logic [5:0]         ev;
    logic [4:0]         err_n;
    logic               soft_rst, err_clr, fs_ok, push_load, push_acc, pop_req;
    logic               fc_ok, start_ok, result_ok, timeout, force_err;
    logic [PIXEL_W-1:0] head_dat;
    logic               fifo_empty, fifo_full;
    logic [AW:0]        fifo_level;
    logic               unused_bits;

    assign unused_bits = ^{control_reg[31:7], pixel_reg[31:PIXEL_W]};

    assign ev        = control_reg[5:0] & ~ctrl_d1;
    assign soft_rst  = ev[1];
    assign err_clr   = ev[5] & ~soft_rst;
    assign fs_ok     = ev[3] & ~soft_rst & (state == S_IDLE);
    assign push_load = ev[2] & ~soft_rst & (state == S_LOAD);
    assign pop_req   = cnn.pix_out_valid & cnn.pix_out_ready;
    assign push_acc  = push_load & (~fifo_full | pop_req);
    // The size check counts a pixel pushed in the same cycle as frame complete.
    assign fc_ok     = ev[4] & ~soft_rst & (state == S_LOAD) & (pixel_count + 32'(push_acc) == FRAME_LEN);
    assign start_ok  = ev[0] & ~soft_rst & (state == S_READY);
    assign result_ok = cnn.cnn_result_valid & ~res_d1 & ~soft_rst & (state == S_RUN);
    assign timeout   = (state == S_RUN) & ~result_ok & ~soft_rst & (watchdog == WD_LAST);

    always_comb begin
        err_n = '0;
        if (!soft_rst) begin
            err_n[0] = timeout;
            err_n[1] = (ev[3] & (state != S_IDLE)) | (ev[0] & (state != S_READY));
            err_n[2] = push_load & fifo_full & ~pop_req;
            err_n[3] = ev[4] & (state == S_LOAD) & ~fc_ok;
            err_n[4] = ev[2] & (state != S_LOAD);
        end
    end

    // Protocol slips (bits 1 and 4) are only recorded; the others abort the frame.
    assign force_err = err_n[0] | err_n[2] | err_n[3];

    cnn_frame_sequencer_fifo #(.W(PIXEL_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (soft_rst | fs_ok),
        .push     (push_load),
        .push_dat (pixel_reg[PIXEL_W-1:0]),
        .pop      (cnn.pix_out_ready),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .level    (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            ctrl_d1         <= '0;
            res_d1          <= 1'b0;
            pixel_count     <= '0;
            watchdog        <= '0;
            done            <= 1'b0;
            frame_count_reg <= '0;
            error_code_reg  <= '0;
            cnn_start_q     <= 1'b0;
            cnn_reset_q     <= 1'b0;
            frame_start     <= 1'b0;
            frame_complete  <= 1'b0;
            irq             <= 1'b0;
        end else begin
            ctrl_d1        <= control_reg[5:0];
            res_d1         <= cnn.cnn_result_valid;
            cnn_reset_q    <= soft_rst;
            frame_start    <= fs_ok;
            frame_complete <= fc_ok & ~force_err;
            cnn_start_q    <= start_ok;
            irq            <= control_reg[6] & (done | (|error_code_reg));
            error_code_reg <= (soft_rst | err_clr) ? {27'b0, err_n} : (error_code_reg | {27'b0, err_n});
            watchdog       <= (state == S_RUN) ? watchdog + 32'd1 : '0;

            if (soft_rst || fs_ok) pixel_count <= '0;
            else                   pixel_count <= pixel_count + 32'(push_acc);

            if (soft_rst || fs_ok) done <= 1'b0;
            else if (result_ok)    done <= 1'b1;

            if (result_ok) frame_count_reg <= frame_count_reg + 1'b1;

            if (soft_rst)                         state <= S_IDLE;
            else if (err_clr && state == S_ERROR) state <= S_IDLE;
            else if (fs_ok)                       state <= S_LOAD;
            else if (force_err)                   state <= S_ERROR;
            else if (fc_ok)                       state <= S_READY;
            else if (start_ok)                    state <= S_RUN;
            else if (result_ok)                   state <= S_IDLE;
        end
    end

    assign cnn.cnn_start     = cnn_start_q;
    assign cnn.cnn_reset     = cnn_reset_q;
    assign cnn.pix_out_valid = ~fifo_empty;
    assign cnn.pix_out_data  = head_dat;

    assign status_reg = {pixel_count[15:0], 7'(fifo_level), |error_code_reg, done, state,
                         fifo_full, fifo_empty, cnn.cnn_result_valid, cnn.cnn_busy};
endmodule
